// File: rtl/decode_regfile.sv
// Decode stage with its register file: turns icode/rA/rB into source and
// destination indices, and holds fifteen 64-bit registers with two write ports.
module decode_regfile #(
    parameter logic [3:0] RSP_ID = 4'h4,
    parameter logic [3:0] RNONE  = 4'hF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  icode_i,
    input  logic [3:0]  rA_i,
    input  logic [3:0]  rB_i,
    input  logic        instr_valid_i,
    input  logic        cnd_i,
    input  logic [3:0]  wb_dstE_i,
    input  logic [63:0] wb_valE_i,
    input  logic [3:0]  wb_dstM_i,
    input  logic [63:0] wb_valM_i,
    output logic [3:0]  srcA_o,
    output logic [3:0]  srcB_o,
    output logic [3:0]  dstE_o,
    output logic [3:0]  dstM_o,
    output logic [63:0] valA_o,
    output logic [63:0] valB_o
);

    localparam int NREGS = 15;

    logic [63:0] regs_q [NREGS];
    logic [63:0] regs_d [NREGS];
    logic [3:0]  src_a_s;
    logic [3:0]  src_b_s;
    logic [3:0]  dst_e_s;
    logic [3:0]  dst_m_s;
    logic [63:0] val_a_s;
    logic [63:0] val_b_s;

    // Register index selection from the instruction code
    always_comb begin
        src_a_s = RNONE;
        src_b_s = RNONE;
        dst_e_s = RNONE;
        dst_m_s = RNONE;
        if (instr_valid_i) begin
            case (icode_i)
                4'h2: begin
                    src_a_s = rA_i;
                    if (cnd_i) begin
                        dst_e_s = rB_i;
                    end else begin
                        dst_e_s = RNONE;
                    end
                end
                4'h3: dst_e_s = rB_i;
                4'h4: begin
                    src_a_s = rA_i;
                    src_b_s = rB_i;
                end
                4'h5: begin
                    src_b_s = rB_i;
                    dst_m_s = rA_i;
                end
                4'h6: begin
                    src_a_s = rA_i;
                    src_b_s = rB_i;
                    dst_e_s = rB_i;
                end
                4'h8: begin
                    src_b_s = RSP_ID;
                    dst_e_s = RSP_ID;
                end
                4'h9: begin
                    src_a_s = RSP_ID;
                    src_b_s = RSP_ID;
                    dst_e_s = RSP_ID;
                end
                4'hA: begin
                    src_a_s = rA_i;
                    src_b_s = RSP_ID;
                    dst_e_s = RSP_ID;
                end
                4'hB: begin
                    src_a_s = RSP_ID;
                    src_b_s = RSP_ID;
                    dst_e_s = RSP_ID;
                    dst_m_s = rA_i;
                end
                default: begin
                    src_a_s = RNONE;
                    src_b_s = RNONE;
                    dst_e_s = RNONE;
                    dst_m_s = RNONE;
                end
            endcase
        end else begin
            src_a_s = RNONE;
            src_b_s = RNONE;
            dst_e_s = RNONE;
            dst_m_s = RNONE;
        end
    end

    // Read ports see pre-edge contents only; RNONE and index F read as zero
    always_comb begin
        val_a_s = 64'h0;
        val_b_s = 64'h0;
        for (int i = 0; i < NREGS; i++) begin
            if ((src_a_s == 4'(i)) && (src_a_s != RNONE)) begin
                val_a_s = regs_q[i];
            end else begin
                val_a_s = val_a_s;
            end
            if ((src_b_s == 4'(i)) && (src_b_s != RNONE)) begin
                val_b_s = regs_q[i];
            end else begin
                val_b_s = val_b_s;
            end
        end
    end

    // Next register state; the M port takes priority on an address clash
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if ((wb_dstM_i == 4'(i)) && (wb_dstM_i != RNONE)) begin
                regs_d[i] = wb_valM_i;
            end else if ((wb_dstE_i == 4'(i)) && (wb_dstE_i != RNONE)) begin
                regs_d[i] = wb_valE_i;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Register storage with synchronous clear that overrides writeback
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NREGS; i++) begin
            if (rst_i) begin
                regs_q[i] <= 64'h0;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign srcA_o = src_a_s;
    assign srcB_o = src_b_s;
    assign dstE_o = dst_e_s;
    assign dstM_o = dst_m_s;
    assign valA_o = val_a_s;
    assign valB_o = val_b_s;

endmodule

// File: tb/tb_decode_regfile.sv
// Self-checking bench for decode_regfile: a per-cycle reference model plus
// hand-computed directed checks.
module tb_decode_regfile;

    localparam logic [3:0] RSP = 4'h4;
    localparam logic [3:0] NO  = 4'hF;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  icode_i, rA_i, rB_i;
    logic        instr_valid_i, cnd_i;
    logic [3:0]  wb_dstE_i, wb_dstM_i;
    logic [63:0] wb_valE_i, wb_valM_i;
    logic [3:0]  srcA_o, srcB_o, dstE_o, dstM_o;
    logic [63:0] valA_o, valB_o;

    int checks = 0;
    int failures = 0;

    logic [63:0] mreg [16];
    logic        known = 1'b0;

    decode_regfile #(.RSP_ID(4'h4), .RNONE(4'hF)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .icode_i(icode_i), .rA_i(rA_i), .rB_i(rB_i),
        .instr_valid_i(instr_valid_i), .cnd_i(cnd_i),
        .wb_dstE_i(wb_dstE_i), .wb_valE_i(wb_valE_i),
        .wb_dstM_i(wb_dstM_i), .wb_valM_i(wb_valM_i),
        .srcA_o(srcA_o), .srcB_o(srcB_o), .dstE_o(dstE_o), .dstM_o(dstM_o),
        .valA_o(valA_o), .valB_o(valB_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode from the instruction-class tables
    function automatic void model_dec(input logic [3:0] ic, input logic [3:0] ra,
                                      input logic [3:0] rb, input logic v, input logic c,
                                      output logic [3:0] sa, output logic [3:0] sb,
                                      output logic [3:0] de, output logic [3:0] dm);
        sa = NO; sb = NO; de = NO; dm = NO;
        if (v) begin
            sa = (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) ? ra :
                 (ic inside {4'h9, 4'hB}) ? RSP : NO;
            sb = (ic inside {4'h4, 4'h5, 4'h6}) ? rb :
                 (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? RSP : NO;
            de = (ic inside {4'h3, 4'h6}) ? rb :
                 (ic == 4'h2 && c) ? rb :
                 (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? RSP : NO;
            dm = (ic inside {4'h5, 4'hB}) ? ra : NO;
        end
    endfunction

    // Model register file: index F is never written, so it always reads zero
    always @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 16; i++) mreg[i] <= 64'h0;
            known <= 1'b1;
        end else begin
            if (wb_dstE_i != NO) mreg[wb_dstE_i] <= wb_valE_i;
            if (wb_dstM_i != NO) mreg[wb_dstM_i] <= wb_valM_i;
        end
    end

    // Compare every output against the model each cycle once state is known
    always @(negedge clk_i) begin
        logic [3:0] sa, sb, de, dm;
        if (known) begin
            model_dec(icode_i, rA_i, rB_i, instr_valid_i, cnd_i, sa, sb, de, dm);
            check("m_srcA", {60'h0, srcA_o}, {60'h0, sa});
            check("m_srcB", {60'h0, srcB_o}, {60'h0, sb});
            check("m_dstE", {60'h0, dstE_o}, {60'h0, de});
            check("m_dstM", {60'h0, dstM_o}, {60'h0, dm});
            check("m_valA", valA_o, mreg[sa]);
            check("m_valB", valB_o, mreg[sb]);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic dec(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic v, input logic c);
        icode_i = ic; rA_i = ra; rB_i = rb; instr_valid_i = v; cnd_i = c;
    endtask

    task automatic wb(input logic [3:0] de, input logic [63:0] ve,
                      input logic [3:0] dm, input logic [63:0] vm);
        wb_dstE_i = de; wb_valE_i = ve; wb_dstM_i = dm; wb_valM_i = vm;
    endtask

    initial begin
        rst_i = 1'b1;
        wb(NO, 64'h0, NO, 64'h0);
        dec(4'h0, NO, NO, 1'b0, 1'b0);
        tick();
        tick();
        rst_i = 1'b0;

        // Every index reads zero after reset
        for (int i = 0; i < 15; i++) begin
            dec(4'h4, 4'(i), 4'(14 - i), 1'b1, 1'b0);
            @(negedge clk_i);
            check("rst_valA", valA_o, 64'h0);
            tick();
        end

        dec(4'h6, 4'h3, 4'h8, 1'b1, 1'b0);
        @(negedge clk_i);
        check("opq_srcA", {60'h0, srcA_o}, 64'h3);
        check("opq_srcB", {60'h0, srcB_o}, 64'h8);
        check("opq_dstE", {60'h0, dstE_o}, 64'h8);
        check("opq_dstM", {60'h0, dstM_o}, 64'hF);
        check("opq_valA", valA_o, 64'h0);
        check("opq_valB", valB_o, 64'h0);
        tick();

        wb(4'h8, 64'h8, NO, 64'h0);
        tick();
        wb(4'h3, 64'h15, NO, 64'h0);
        tick();
        wb(NO, 64'h0, NO, 64'h0);
        dec(4'h2, 4'h8, 4'h3, 1'b1, 1'b1);
        @(negedge clk_i);
        check("cmov_valA", valA_o, 64'h8);
        check("cmov_dstE", {60'h0, dstE_o}, 64'h3);
        check("cmov_valB", valB_o, 64'h0);
        cnd_i = 1'b0;
        #1;
        check("cmov_nc_dstE", {60'h0, dstE_o}, 64'hF);
        tick();

        wb(4'h4, 64'h100, 4'h4, 64'h200);
        tick();
        wb(NO, 64'h0, NO, 64'h0);
        dec(4'h9, NO, NO, 1'b1, 1'b0);
        @(negedge clk_i);
        check("pop_srcA", {60'h0, srcA_o}, 64'h4);
        check("pop_srcB", {60'h0, srcB_o}, 64'h4);
        check("pop_valA", valA_o, 64'h200);
        check("pop_valB", valB_o, 64'h200);
        tick();

        wb(4'h5, 64'h55, NO, 64'h0);
        tick();
        wb(4'h5, 64'hAA, NO, 64'h0);
        dec(4'h4, 4'h5, 4'h0, 1'b1, 1'b0);
        @(negedge clk_i);
        check("nobyp_old", valA_o, 64'h55);
        tick();
        wb(NO, 64'h0, NO, 64'h0);
        @(negedge clk_i);
        check("nobyp_new", valA_o, 64'hAA);
        tick();

        wb(4'h1, 64'h11, 4'h2, 64'h22);
        tick();
        wb(NO, 64'h0, NO, 64'h0);
        dec(4'h6, 4'h1, 4'h2, 1'b1, 1'b0);
        @(negedge clk_i);
        check("dual_valA", valA_o, 64'h11);
        check("dual_valB", valB_o, 64'h22);
        tick();

        dec(4'hB, 4'h2, 4'h0, 1'b1, 1'b0);
        @(negedge clk_i);
        check("popB_srcA", {60'h0, srcA_o}, 64'h4);
        check("popB_srcB", {60'h0, srcB_o}, 64'h4);
        check("popB_dstE", {60'h0, dstE_o}, 64'h4);
        check("popB_dstM", {60'h0, dstM_o}, 64'h2);
        instr_valid_i = 1'b0;
        #1;
        check("inv_srcA", {60'h0, srcA_o}, 64'hF);
        check("inv_srcB", {60'h0, srcB_o}, 64'hF);
        check("inv_dstE", {60'h0, dstE_o}, 64'hF);
        check("inv_dstM", {60'h0, dstM_o}, 64'hF);
        check("inv_valA", valA_o, 64'h0);
        check("inv_valB", valB_o, 64'h0);
        tick();

        // Sweep all icodes, valid and invalid, against the model
        for (int ic = 0; ic < 16; ic++) begin
            for (int v = 0; v < 2; v++) begin
                dec(4'(ic), 4'h7, 4'h1, v[0], ic[0]);
                tick();
            end
        end

        for (int i = 0; i < 15; i++) begin
            wb(4'(i), 64'hA000 + 64'(i), NO, 64'h0);
            tick();
        end
        rst_i = 1'b1;
        wb(4'h1, 64'hFFFF, NO, 64'h0);
        tick();
        rst_i = 1'b0;
        wb(NO, 64'h0, NO, 64'h0);
        for (int i = 0; i < 15; i++) begin
            dec(4'h4, 4'(i), 4'(i), 1'b1, 1'b0);
            @(negedge clk_i);
            check("clr_valA", valA_o, 64'h0);
            check("clr_valB", valB_o, 64'h0);
            tick();
        end

        rst_i = 1'b1;
        wb(4'h3, 64'h33, NO, 64'h0);
        tick();
        rst_i = 1'b0;
        wb(4'h3, 64'h44, NO, 64'h0);
        tick();
        wb(NO, 64'h0, NO, 64'h0);
        dec(4'h4, 4'h3, 4'h3, 1'b1, 1'b0);
        @(negedge clk_i);
        check("first_wr", valA_o, 64'h44);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
